// File: rtl/pipeline_fifo.sv
// pipeline_fifo: first-word-fall-through FIFO with valid/backpressure on both
// sides. Sits upstream of the pipeline registers to absorb bursts. The head
// token and all handshake outputs come only from registered state, so there
// is no combinational path from d/d_valid to q/q_valid or from q_bp to d_bp.
module pipeline_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4,
    parameter int CW    = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] d,
    input  logic             d_valid,
    output logic             d_bp,
    output logic [Width-1:0] q,
    output logic             q_valid,
    input  logic             q_bp,
    output logic [CW-1:0]    count
);

    // Pointer width; a single-slot FIFO still carries a 1-bit pointer that
    // never leaves zero.
    localparam int            PW       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_incoming;
    logic             w_outgoing;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // Full blocks input even in a cycle where the consumer drains; the freed
    // slot becomes usable on the following cycle.
    assign w_incoming = d_valid && !w_full;
    assign w_outgoing = !w_empty && !q_bp;

    assign d_bp    = w_full;
    assign q_valid = !w_empty;
    assign q       = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Token storage: written on accept, never reset.
    always_ff @(posedge clk) begin
        if (w_incoming) begin
            r_mem[r_wr_ptr] <= d;
        end
    end

    // Read/write pointers with explicit wrap at Depth-1 (Depth need not be a
    // power of two).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_incoming) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_outgoing) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous accept and drain leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            case ({w_incoming, w_outgoing})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_fifo.sv
// tb_pipeline_fifo: directed checks of pipeline_fifo at Depth 4, 3, 2 and 1.
// Inputs are driven 1 time unit after the rising edge; outputs are compared
// at that same point, away from the active edge.
module tb_pipeline_fifo;

    logic clk;
    logic resetn;

    // Depth = 4 instance
    logic [7:0] d4, q4;
    logic       dv4, bp4, qv4, qbp4;
    logic [2:0] cnt4;
    // Depth = 3 instance
    logic [7:0] d3, q3;
    logic       dv3, bp3, qv3, qbp3;
    logic [1:0] cnt3;
    // Depth = 2 instance
    logic [7:0] d2, q2;
    logic       dv2, bp2, qv2, qbp2;
    logic [1:0] cnt2;
    // Depth = 1 instance
    logic [7:0] d1, q1;
    logic       dv1, bp1, qv1, qbp1;
    logic [0:0] cnt1;

    int vecs = 0;
    int errs = 0;

    pipeline_fifo #(.Width(8), .Depth(4)) u_fifo4 (
        .clk(clk), .resetn(resetn), .d(d4), .d_valid(dv4), .d_bp(bp4),
        .q(q4), .q_valid(qv4), .q_bp(qbp4), .count(cnt4)
    );
    pipeline_fifo #(.Width(8), .Depth(3)) u_fifo3 (
        .clk(clk), .resetn(resetn), .d(d3), .d_valid(dv3), .d_bp(bp3),
        .q(q3), .q_valid(qv3), .q_bp(qbp3), .count(cnt3)
    );
    pipeline_fifo #(.Width(8), .Depth(2)) u_fifo2 (
        .clk(clk), .resetn(resetn), .d(d2), .d_valid(dv2), .d_bp(bp2),
        .q(q2), .q_valid(qv2), .q_bp(qbp2), .count(cnt2)
    );
    pipeline_fifo #(.Width(8), .Depth(1)) u_fifo1 (
        .clk(clk), .resetn(resetn), .d(d1), .d_valid(dv1), .d_bp(bp1),
        .q(q1), .q_valid(qv1), .q_bp(qbp1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        d4 = '0; dv4 = 0; qbp4 = 0;
        d3 = '0; dv3 = 0; qbp3 = 0;
        d2 = '0; dv2 = 0; qbp2 = 0;
        d1 = '0; dv1 = 0; qbp1 = 0;
        tick();
        tick();
        vecs++;
        if ({qv4, bp4, cnt4} !== 5'b0) begin
            errs++;
            $display("FAIL reset_d4: got qv=%b bp=%b cnt=%0d, need 0 0 0", qv4, bp4, cnt4);
        end
        vecs++;
        if ({qv3, bp3, cnt3, qv2, bp2, cnt2, qv1, bp1, cnt1} !== 11'b0) begin
            errs++;
            $display("FAIL reset_others: got d3 %b%b%0d d2 %b%b%0d d1 %b%b%0d, need all 0",
                     qv3, bp3, cnt3, qv2, bp2, cnt2, qv1, bp1, cnt1);
        end
        resetn = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_q   [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        logic [2:0] exp_cnt [4] = '{3'd3, 3'd3, 3'd2, 3'd1};
        qbp4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4 = 8'hA1 + 8'(i);
            dv4 = 1'b1;
            tick();
            vecs++;
            if (cnt4 !== 3'(i + 1)) begin
                errs++;
                $display("FAIL fill_count[%0d]: got %0d, need %0d", i, cnt4, i + 1);
            end
        end
        vecs++;
        if (bp4 !== 1'b1 || qv4 !== 1'b1 || q4 !== 8'hA1) begin
            errs++;
            $display("FAIL fill_full: got bp=%b qv=%b q=%h, need 1 1 a1", bp4, qv4, q4);
        end
        // A5 presented while full and blocked: must be held, not accepted.
        d4 = 8'hA5;
        tick();
        vecs++;
        if (cnt4 !== 3'd4 || q4 !== 8'hA1 || bp4 !== 1'b1) begin
            errs++;
            $display("FAIL fill_hold: got cnt=%0d q=%h bp=%b, need 4 a1 1", cnt4, q4, bp4);
        end
        qbp4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vecs++;
            if (q4 !== exp_q[k] || cnt4 !== exp_cnt[k] || qv4 !== 1'b1) begin
                errs++;
                $display("FAIL drain[%0d]: got q=%h cnt=%0d qv=%b, need %h %0d 1",
                         k, q4, cnt4, qv4, exp_q[k], exp_cnt[k]);
            end
            if (k == 1) dv4 = 1'b0;
        end
        tick();
        vecs++;
        if (qv4 !== 1'b0 || cnt4 !== 3'd0 || bp4 !== 1'b0) begin
            errs++;
            $display("FAIL drain_empty: got qv=%b cnt=%0d bp=%b, need 0 0 0", qv4, cnt4, bp4);
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_streaming();
        qbp4 = 1'b0;
        d4 = 8'd0;
        dv4 = 1'b1;
        vecs++;
        if (qv4 !== 1'b0) begin
            errs++;
            $display("FAIL stream_nobypass: got qv=%b, need 0", qv4);
        end
        for (int n = 0; n < 10; n++) begin
            tick();
            vecs++;
            if (qv4 !== 1'b1 || q4 !== 8'(n) || cnt4 !== 3'd1) begin
                errs++;
                $display("FAIL stream[%0d]: got qv=%b q=%0d cnt=%0d, need 1 %0d 1",
                         n, qv4, q4, cnt4, n);
            end
            d4 = 8'(n + 1);
        end
        dv4 = 1'b0;
        tick();
        vecs++;
        if (qv4 !== 1'b0 || cnt4 !== 3'd0) begin
            errs++;
            $display("FAIL stream_end: got qv=%b cnt=%0d, need 0 0", qv4, cnt4);
        end
        $display("test_streaming done");
    endtask

    task automatic test_wrap();
        logic [7:0] model[$];
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic inc, outg;
        dv3 = 1'b0;
        while (popped < 10 && cyc < 400) begin
            if (!dv3 && pushed < 10 && $urandom_range(0, 1) == 1) begin
                dv3 = 1'b1;
                d3 = 8'h30 + 8'(pushed);
            end
            qbp3 = 1'($urandom_range(0, 1));
            vecs++;
            if (cnt3 !== 2'(model.size()) || bp3 !== (model.size() == 3) ||
                qv3 !== (model.size() != 0)) begin
                errs++;
                $display("FAIL wrap_state[%0d]: got cnt=%0d bp=%b qv=%b, need cnt=%0d",
                         cyc, cnt3, bp3, qv3, model.size());
            end
            if (model.size() != 0) begin
                vecs++;
                if (q3 !== model[0]) begin
                    errs++;
                    $display("FAIL wrap_data[%0d]: got %h, need %h", cyc, q3, model[0]);
                end
            end
            inc  = dv3 && !bp3;
            outg = qv3 && !qbp3;
            tick();
            if (outg && model.size() != 0) begin
                void'(model.pop_front());
                popped++;
            end
            if (inc) begin
                model.push_back(d3);
                pushed++;
                dv3 = 1'b0;
            end
            cyc++;
        end
        vecs++;
        if (popped != 10) begin
            errs++;
            $display("FAIL wrap_done: got %0d tokens out, need 10", popped);
        end
        qbp3 = 1'b0;
        $display("test_wrap done");
    endtask

    task automatic test_full_drain();
        qbp2 = 1'b1;
        dv2 = 1'b1;
        d2 = 8'h11;
        tick();
        d2 = 8'h22;
        tick();
        vecs++;
        if (cnt2 !== 2'd2 || bp2 !== 1'b1) begin
            errs++;
            $display("FAIL full2_fill: got cnt=%0d bp=%b, need 2 1", cnt2, bp2);
        end
        d2 = 8'h33;
        qbp2 = 1'b0;
        tick();
        vecs++;
        if (cnt2 !== 2'd1 || bp2 !== 1'b0 || q2 !== 8'h22) begin
            errs++;
            $display("FAIL full2_drain: got cnt=%0d bp=%b q=%h, need 1 0 22", cnt2, bp2, q2);
        end
        tick();
        vecs++;
        if (cnt2 !== 2'd1 || q2 !== 8'h33) begin
            errs++;
            $display("FAIL full2_next: got cnt=%0d q=%h, need 1 33", cnt2, q2);
        end
        dv2 = 1'b0;
        tick();
        vecs++;
        if (cnt2 !== 2'd0 || qv2 !== 1'b0) begin
            errs++;
            $display("FAIL full2_empty: got cnt=%0d qv=%b, need 0 0", cnt2, qv2);
        end
        $display("test_full_drain done");
    endtask

    task automatic test_depth1();
        qbp1 = 1'b0;
        dv1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            d1 = 8'h40 + 8'(c / 2);
            vecs++;
            if (qv1 !== 1'(c % 2) || bp1 !== 1'(c % 2)) begin
                errs++;
                $display("FAIL d1_hs[%0d]: got qv=%b bp=%b, need %0d %0d",
                         c, qv1, bp1, c % 2, c % 2);
            end
            if (c % 2 == 1) begin
                vecs++;
                if (q1 !== 8'h40 + 8'((c - 1) / 2)) begin
                    errs++;
                    $display("FAIL d1_data[%0d]: got %h, need %h", c, q1, 8'h40 + 8'((c - 1) / 2));
                end
            end
            tick();
        end
        dv1 = 1'b0;
        tick();
        $display("test_depth1 done");
    endtask

    task automatic test_async_reset();
        qbp4 = 1'b1;
        dv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d4 = 8'h71 + 8'(i);
            tick();
        end
        dv4 = 1'b0;
        vecs++;
        if (cnt4 !== 3'd3) begin
            errs++;
            $display("FAIL areset_pre: got cnt=%0d, need 3", cnt4);
        end
        // Assert reset between edges: outputs must clear before the next edge.
        #2;
        resetn = 1'b0;
        #1;
        vecs++;
        if (qv4 !== 1'b0 || cnt4 !== 3'd0 || bp4 !== 1'b0) begin
            errs++;
            $display("FAIL areset_now: got qv=%b cnt=%0d bp=%b, need 0 0 0", qv4, cnt4, bp4);
        end
        tick();
        resetn = 1'b1;
        qbp4 = 1'b0;
        dv4 = 1'b1;
        d4 = 8'h5C;
        tick();
        dv4 = 1'b0;
        vecs++;
        if (qv4 !== 1'b1 || q4 !== 8'h5C || cnt4 !== 3'd1) begin
            errs++;
            $display("FAIL areset_after: got qv=%b q=%h cnt=%0d, need 1 5c 1", qv4, q4, cnt4);
        end
        tick();
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_wrap();
        test_full_drain();
        test_depth1();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
